sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Single-clock arbiter and sequencer for the one-port data SRAM behind the AXI slave. It sits between the read beat engine (fed by the AR/R channels) and the write beat engine (fed by the AW/W/B channels) and the SRAM macro. It grants the port to one engine per burst, using round-robin when both request, and drives the SRAM address, data, byte-write-enable and output-enable pins. It replaces the free-running IDLE/BUSY select logic with an explicit burst-level grant, a direct handoff between engines and a stall watchdog.

## Interface
Parameters:
- ADDR_W, 14, SRAM word-address width; addresses use byte address bits [ADDR_W+1:2]
- TIMEOUT, 16, maximum number of cycles a granted engine may go without a beat before the grant is revoked (≥2)

Ports:
- ACLK in 1: clock. Single clock domain.
- ARESETn in 1: reset, asynchronous, active-low.
- rd_req in 1: read engine requests the port; held high until rd_gnt is seen.
- rd_addr in 32: byte address of the current read beat.
- rd_en in 1: perform a read access this cycle.
- rd_last in 1: qualifies rd_en as the final beat of the burst.
- rd_gnt out 1: port owned by the read engine.
- rd_data out 32: read data, equal to sram_do.
- rd_data_valid out 1: rd_data is valid this cycle.
- wr_req in 1: write engine request, same rules as rd_req.
- wr_addr in 32: byte address of the current write beat.
- wr_data in 32: write data.
- wr_strb in 4: byte strobes.
- wr_en in 1: perform a write access this cycle.
- wr_last in 1: qualifies wr_en as the final beat of the burst.
- wr_gnt out 1: port owned by the write engine.
- timeout_err out 1: one-cycle pulse when a grant is revoked by the watchdog.
- sram_cs out 1: SRAM chip select.
- sram_oe out 1: SRAM output enable.
- sram_web out 4: active-low byte write enables.
- sram_a out ADDR_W: SRAM word address.
- sram_di out 32: SRAM write data.
- sram_do in 32: SRAM read data, valid the cycle after the read edge.

## Operation
- FSM states are IDLE, RD and WR. rd_gnt = (state==RD) and wr_gnt = (state==WR), both registered.
- A priority flag prio (0 = read first) is updated each time a grant is issued. It points away from the engine just granted.
- IDLE transitions:
  - only rd_req high → RD
  - only wr_req high → WR
  - both high → the engine selected by prio
  - neither high → stay in IDLE
- RD/WR transitions:
  - A beat (en & last) moves the FSM to the other state if the other engine's req is high; otherwise to IDLE. The same engine never keeps the port across a last beat.
  - A watchdog expiry moves the FSM to IDLE, regardless of requests.
- Beats:
  - rd_en or wr_en is honoured only while the matching grant is high; otherwise it is ignored. last without en is ignored.
- SRAM pins (combinational from state and inputs):
  - sram_a = rd_addr[ADDR_W+1:2] in RD, wr_addr[ADDR_W+1:2] in WR, 0 in IDLE.
  - sram_di = wr_data.
  - sram_web = ~wr_strb when wr_gnt & wr_en; otherwise 4'hF.
  - sram_cs = (state != IDLE).
- Read data: sram_oe and rd_data_valid are a single register loaded with (rd_gnt & rd_en). rd_data is sram_do passed through.
- Watchdog:
  - A counter of width clog2(TIMEOUT) clears on IDLE, on any honoured beat, and on any grant change.
  - The counter increments on each granted cycle without a beat.
  - When the counter reaches TIMEOUT-1 with no beat that cycle: grant is revoked (next state IDLE) and timeout_err pulses in the following cycle.

## Timing
- Reset values:
  - state IDLE, prio 0, counter 0
  - rd_gnt, wr_gnt, rd_data_valid, sram_oe, timeout_err, sram_cs all 0
  - sram_web 4'hF, sram_a 0
  - Reset applies immediately on ARESETn falling, including mid-burst; no SRAM write may occur during reset.
- Request in IDLE at cycle N → grant high at N+1. The first beat is allowed at N+1.
- Read beat at cycle k → rd_data_valid and sram_oe high at k+1, with rd_data = data at that address.
- Write beat at cycle k → the SRAM writes on the rising edge that ends cycle k.
- Last beat at cycle k:
  - grant low at k+1
  - other engine's grant high at k+1 if it was requesting (zero-bubble handoff)
  - otherwise IDLE at k+1, and the earliest regrant is k+2
- Back-to-back beats: one per cycle, no stall inserted.
- Watchdog: grant at cycle g with no beats → grant low at g+TIMEOUT, timeout_err high during g+TIMEOUT only.

## Test plan
- Reset: hold ARESETn low with random inputs → gnts 0, sram_web 4'hF, sram_cs 0, sram_a 0, rd_data_valid 0. Drop ARESETn mid-write-burst → sram_web 4'hF with no clock edge.
- Read burst of 4: rd_req at cycle 0 → rd_gnt at 1. Beats at 1–4 with addresses 0x100–0x10C (last at 4) → sram_a = 0x40..0x43, rd_data_valid at 2–5 returning preloaded data, rd_gnt low at 5, state IDLE.
- Write single beat, wr_data=0xDEADBEEF, wr_strb=4'b0011, address 0x20 → sram_web = 4'b1100 for one cycle. A later read of 0x20 returns the old upper half with 0xBEEF in the low half.
- Simultaneous rd_req/wr_req from reset → RD first. With wr_req held, the read's last beat hands over to WR in the next cycle with no bubble. Both requests again from IDLE → RD wins (prio points to read after the write grant).
- Watchdog, TIMEOUT=16: wr_gnt at cycle 5 with no beats → wr_gnt low at 21, timeout_err high at 21 only. A pending rd_req is then granted at 22.
- Ungranted rd_en with wr_gnt held → sram_web and sram_a follow the write engine only, and rd_data_valid stays 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter_if
//  Description : Bundle of the read-engine, write-engine and SRAM-macro
//                signals around the one-port data SRAM arbiter.
//                slave  modport : the arbiter's view
//                master modport : the environment (engines + SRAM macro)
//  Ports       : rd_req/rd_addr/rd_en/rd_last -> rd_gnt/rd_data/rd_data_valid
//                wr_req/wr_addr/wr_data/wr_strb/wr_en/wr_last -> wr_gnt
//                timeout_err, sram_cs/oe/web/a/di (to macro), sram_do (from)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic              rd_en;
    logic              rd_last;
    logic              rd_gnt;
    logic [31:0]       rd_data;
    logic              rd_data_valid;

    logic              wr_req;
    logic [31:0]       wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_en;
    logic              wr_last;
    logic              wr_gnt;

    logic              timeout_err;

    logic              sram_cs;
    logic              sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [31:0]       sram_di;
    logic [31:0]       sram_do;

    modport slave (
        input  rd_req, rd_addr, rd_en, rd_last,
        output rd_gnt, rd_data, rd_data_valid,
        input  wr_req, wr_addr, wr_data, wr_strb, wr_en, wr_last,
        output wr_gnt, timeout_err,
        output sram_cs, sram_oe, sram_web, sram_a, sram_di,
        input  sram_do
    );

    modport master (
        output rd_req, rd_addr, rd_en, rd_last,
        input  rd_gnt, rd_data, rd_data_valid,
        output wr_req, wr_addr, wr_data, wr_strb, wr_en, wr_last,
        input  wr_gnt, timeout_err,
        input  sram_cs, sram_oe, sram_web, sram_a, sram_di,
        output sram_do
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Burst-level arbiter/sequencer for the one-port data SRAM.
//                Grants the port to the read or write engine for a whole
//                burst (round-robin on contention), hands over directly on
//                the last beat, and revokes a stalled grant via a watchdog.
//  Ports       : ACLK    - clock
//                ARESETn - asynchronous active-low reset
//                bus     - sram_port_arbiter_if.slave (engines + SRAM pins)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  wire logic            ACLK,
    input  wire logic            ARESETn,
    sram_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;       // 0: read wins a tie, 1: write wins
    logic [CNT_W-1:0]  cnt_q, cnt_d;         // granted cycles since last beat
    logic              oe_q;
    logic              to_q, to_d;

    logic              w_rd_beat;
    logic              w_wr_beat;
    logic              w_beat;
    logic              w_expire;

    // Beats only count while the matching grant is held.
    assign w_rd_beat = (state_q == S_RD) && bus.rd_en;
    assign w_wr_beat = (state_q == S_WR) && bus.wr_en;
    assign w_beat    = w_rd_beat || w_wr_beat;
    assign w_expire  = (state_q != S_IDLE) && !w_beat && (cnt_q == C_CNT_MAX);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rd_req && (!bus.wr_req || !prio_q)) begin
                    state_d = S_RD;
                end else if (bus.wr_req) begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                if (w_rd_beat && bus.rd_last) begin
                    state_d = bus.wr_req ? S_WR : S_IDLE;
                end else if (w_expire) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end
            S_WR: begin
                if (w_wr_beat && bus.wr_last) begin
                    state_d = bus.rd_req ? S_RD : S_IDLE;
                end else if (w_expire) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every fresh grant points the tie-break at the other engine.
        if ((state_d != state_q) && (state_d != S_IDLE)) begin
            prio_d = (state_d == S_RD);
        end

        if ((state_q == S_IDLE) || w_beat || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            oe_q    <= w_rd_beat;
            to_q    <= to_d;
        end
    end

    assign bus.rd_gnt        = (state_q == S_RD);
    assign bus.wr_gnt        = (state_q == S_WR);
    assign bus.rd_data       = bus.sram_do;
    assign bus.rd_data_valid = oe_q;
    assign bus.sram_oe       = oe_q;
    assign bus.timeout_err   = to_q;

    // SRAM pins decode straight off the state register so that an
    // asynchronous reset blocks writes without waiting for a clock edge.
    assign bus.sram_cs  = (state_q != S_IDLE);
    assign bus.sram_di  = bus.wr_data;
    assign bus.sram_web = w_wr_beat ? ~bus.wr_strb : 4'hF;
    assign bus.sram_a   = (state_q == S_RD) ? bus.rd_addr[ADDR_W+1:2] :
                          (state_q == S_WR) ? bus.wr_addr[ADDR_W+1:2] :
                                              '0;

    // Byte-offset and above-range address bits are don't-care for a word SRAM.
    logic w_unused;
    assign w_unused = &{1'b0, bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                        bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Self-checking bench for sram_port_arbiter with a behavioural
//                SRAM macro, directed scenarios and a randomized run checked
//                against a burst-level ownership/memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;
    localparam int MEMW    = 1 << ADDR_W;

    logic clk;
    logic rst_n;
    logic preload;
    int   checks;
    int   errors;
    int   reset_wr_cnt;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return {16'h5A00 ^ 16'(i), ~16'(i)};
    endfunction

    // ---------------- behavioural SRAM macro ----------------
    logic [31:0] sram_mem [0:MEMW-1];
    logic [31:0] do_r;
    assign bus.sram_do = do_r;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEMW; i++) sram_mem[i] <= pat(i);
        end else if (bus.sram_cs) begin
            if (bus.sram_web != 4'hF) begin
                for (int b = 0; b < 4; b++)
                    if (!bus.sram_web[b]) sram_mem[bus.sram_a][8*b +: 8] <= bus.sram_di[8*b +: 8];
            end else begin
                do_r <= sram_mem[bus.sram_a];
            end
        end
        if (!rst_n && (bus.sram_web != 4'hF)) reset_wr_cnt <= reset_wr_cnt + 1;
    end

    // ---------------- bench-side expected memory ----------------
    logic [31:0] ref_mem [0:MEMW-1];

    function automatic void ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req = 0; bus.rd_en = 0; bus.rd_last = 0; bus.rd_addr = 0;
        bus.wr_req = 0; bus.wr_en = 0; bus.wr_last = 0; bus.wr_addr = 0;
        bus.wr_data = 0; bus.wr_strb = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            preload = 0;
            bus.rd_req = 1'($urandom); bus.rd_en = 1'($urandom); bus.rd_last = 1'($urandom);
            bus.rd_addr = $urandom; bus.wr_req = 1'($urandom); bus.wr_en = 1;
            bus.wr_last = 1'($urandom); bus.wr_addr = $urandom; bus.wr_data = $urandom;
            bus.wr_strb = 4'hF;
            #1;
            checks++;
            if ({bus.rd_gnt, bus.wr_gnt} !== 2'b00) begin
                errors++; $display("FAIL reset_gnt: got %b required 00", {bus.rd_gnt, bus.wr_gnt});
            end
            checks++;
            if (bus.sram_web !== 4'hF) begin
                errors++; $display("FAIL reset_web: got %h required f", bus.sram_web);
            end
            checks++;
            if ({bus.sram_cs, bus.sram_oe, bus.rd_data_valid, bus.timeout_err} !== 4'b0000) begin
                errors++; $display("FAIL reset_flags: got %b required 0000",
                    {bus.sram_cs, bus.sram_oe, bus.rd_data_valid, bus.timeout_err});
            end
            checks++;
            if (bus.sram_a !== '0) begin
                errors++; $display("FAIL reset_addr: got %h required 0", bus.sram_a);
            end
        end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_read_burst();
        bus.rd_req = 1;
        #1;
        checks++;
        if (bus.rd_gnt !== 1'b0) begin
            errors++; $display("FAIL rd_gnt_early: got %b required 0", bus.rd_gnt);
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.rd_req  = 0;
            bus.rd_en   = (c <= 4);
            bus.rd_last = (c == 4);
            bus.rd_addr = 32'h100 + 32'(4 * (c - 1));
            #1;
            checks++;
            if (bus.rd_gnt !== (c <= 4)) begin
                errors++; $display("FAIL rd_burst_gnt c%0d: got %b required %b", c, bus.rd_gnt, (c <= 4));
            end
            if (c <= 4) begin
                checks++;
                if (bus.sram_a !== ADDR_W'(32'h40 + c - 1)) begin
                    errors++; $display("FAIL rd_burst_addr c%0d: got %h required %h", c, bus.sram_a, 32'h40 + c - 1);
                end
            end
            checks++;
            if (bus.rd_data_valid !== (c >= 2 && c <= 5) || bus.sram_oe !== (c >= 2 && c <= 5)) begin
                errors++; $display("FAIL rd_burst_valid c%0d: got %b/%b required %b", c,
                    bus.rd_data_valid, bus.sram_oe, (c >= 2 && c <= 5));
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (bus.rd_data !== ref_mem[32'h40 + c - 2]) begin
                    errors++; $display("FAIL rd_burst_data c%0d: got %h required %h", c, bus.rd_data, ref_mem[32'h40 + c - 2]);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.sram_cs !== 1'b0) begin
                    errors++; $display("FAIL rd_burst_idle: cs got %b required 0", bus.sram_cs);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_single();
        bus.wr_req = 1;
        step();
        bus.wr_req = 0; bus.wr_en = 1; bus.wr_last = 1; bus.wr_addr = 32'h20;
        bus.wr_data = 32'hDEADBEEF; bus.wr_strb = 4'b0011;
        #1;
        checks++;
        if (bus.wr_gnt !== 1'b1 || bus.sram_web !== 4'b1100 || bus.sram_a !== ADDR_W'(8)
            || bus.sram_di !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_single: gnt %b web %b a %h di %h required 1 1100 008 deadbeef",
                bus.wr_gnt, bus.sram_web, bus.sram_a, bus.sram_di);
        end
        ref_write(8, 32'hDEADBEEF, 4'b0011);
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.sram_web !== 4'hF || bus.wr_gnt !== 1'b0) begin
            errors++; $display("FAIL wr_single_end: web %h gnt %b required f 0", bus.sram_web, bus.wr_gnt);
        end
        bus.rd_req = 1;
        step();
        bus.rd_req = 0; bus.rd_en = 1; bus.rd_last = 1; bus.rd_addr = 32'h20;
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== {pat(8) >> 16, 16'hBEEF}) begin
            errors++; $display("FAIL wr_readback: valid %b data %h required 1 %h", bus.rd_data_valid,
                bus.rd_data, {pat(8) >> 16, 16'hBEEF});
        end
    endtask

    task automatic test_arbitration();
        rst_n = 0;
        step();
        rst_n = 1;
        bus.rd_req = 1; bus.wr_req = 1;
        step();
        bus.rd_req = 0; bus.rd_en = 1; bus.rd_addr = 32'h0;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.wr_gnt} !== 2'b10) begin
            errors++; $display("FAIL arb_first: rd/wr gnt %b required 10", {bus.rd_gnt, bus.wr_gnt});
        end
        step();
        bus.rd_last = 1;
        step();
        bus.rd_en = 0; bus.rd_last = 0;
        bus.wr_req = 0; bus.wr_en = 1; bus.wr_last = 1; bus.wr_strb = 4'h0;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.wr_gnt} !== 2'b01) begin
            errors++; $display("FAIL arb_handoff: rd/wr gnt %b required 01", {bus.rd_gnt, bus.wr_gnt});
        end
        step();
        idle_inputs();
        bus.rd_req = 1; bus.wr_req = 1;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.wr_gnt} !== 2'b00) begin
            errors++; $display("FAIL arb_idle: rd/wr gnt %b required 00", {bus.rd_gnt, bus.wr_gnt});
        end
        step();
        bus.rd_req = 0; bus.wr_req = 0; bus.rd_en = 1; bus.rd_last = 1;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.wr_gnt} !== 2'b10) begin
            errors++; $display("FAIL arb_rr: rd/wr gnt %b required 10", {bus.rd_gnt, bus.wr_gnt});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_watchdog();
        bus.wr_req = 1;
        step();
        bus.wr_req = 0; bus.rd_req = 1;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            checks++;
            if (bus.wr_gnt !== 1'b1 || bus.timeout_err !== 1'b0) begin
                errors++; $display("FAIL wdog_hold +%0d: gnt %b err %b required 1 0", i, bus.wr_gnt, bus.timeout_err);
            end
            step();
        end
        #1;
        checks++;
        if ({bus.wr_gnt, bus.rd_gnt, bus.timeout_err} !== 3'b001) begin
            errors++; $display("FAIL wdog_expire: wr/rd/err %b required 001", {bus.wr_gnt, bus.rd_gnt, bus.timeout_err});
        end
        step();
        bus.rd_req = 0; bus.rd_en = 1; bus.rd_last = 1;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.timeout_err} !== 2'b10) begin
            errors++; $display("FAIL wdog_regrant: rd/err %b required 10", {bus.rd_gnt, bus.timeout_err});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_ungranted();
        int w;
        bus.wr_req = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            if (i > 0) begin
                checks++;
                if (bus.rd_data_valid !== 1'b0) begin
                    errors++; $display("FAIL ungr_valid %0d: got %b required 0", i, bus.rd_data_valid);
                end
            end
            if (i == 4) break;
            w = 32 + int'($urandom_range(0, 31));
            bus.wr_req = 0; bus.wr_en = 1; bus.wr_last = (i == 3);
            bus.wr_addr = 32'(w << 2); bus.wr_data = $urandom;
            bus.wr_strb = 4'($urandom_range(1, 15));
            bus.rd_en = 1; bus.rd_last = 1; bus.rd_addr = $urandom;
            #1;
            checks++;
            if (bus.sram_a !== ADDR_W'(w) || bus.sram_web !== ~bus.wr_strb || bus.rd_gnt !== 1'b0) begin
                errors++; $display("FAIL ungr_pins %0d: a %h web %b rd_gnt %b required %h %b 0",
                    i, bus.sram_a, bus.sram_web, bus.rd_gnt, w, ~bus.wr_strb);
            end
            ref_write(w, bus.wr_data, bus.wr_strb);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midburst();
        bus.wr_req = 1;
        step();
        bus.wr_req = 0; bus.wr_en = 1; bus.wr_addr = 32'h40; bus.wr_data = 32'h11223344; bus.wr_strb = 4'hF;
        ref_write(16, 32'h11223344, 4'hF);
        step();
        bus.wr_addr = 32'h44; bus.wr_data = 32'h55667788;
        #1;
        checks++;
        if (bus.sram_web !== 4'h0) begin
            errors++; $display("FAIL midrst_pre: web %h required 0", bus.sram_web);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (bus.sram_web !== 4'hF || bus.wr_gnt !== 1'b0 || bus.sram_cs !== 1'b0) begin
            errors++; $display("FAIL midrst_async: web %h gnt %b cs %b required f 0 0", bus.sram_web, bus.wr_gnt, bus.sram_cs);
        end
        step();
        idle_inputs();
        rst_n = 1;
        bus.rd_req = 1;
        step();
        bus.rd_req = 0; bus.rd_en = 1; bus.rd_last = 1; bus.rd_addr = 32'h44;
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.rd_data !== ref_mem[17]) begin
            errors++; $display("FAIL midrst_nowrite: data %h required %h", bus.rd_data, ref_mem[17]);
        end
    endtask

    task automatic test_random();
        int owner, stall, nxt, rw, ww;
        bit prio_wr, exp_valid, exp_to, rb, wb, nv;
        logic [31:0] exp_data, nd;
        rst_n = 0;
        step();
        rst_n = 1;
        owner = 0; stall = 0; prio_wr = 0; exp_valid = 0; exp_to = 0; exp_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit quiet;
            quiet = ((cyc / 150) % 5) == 4;
            rw = int'($urandom_range(0, 31));
            ww = int'($urandom_range(0, 31));
            bus.rd_req  = ($urandom_range(0, 99) < 40);
            bus.wr_req  = ($urandom_range(0, 99) < 40);
            bus.rd_en   = !quiet && ($urandom_range(0, 99) < 60);
            bus.wr_en   = !quiet && ($urandom_range(0, 99) < 60);
            bus.rd_last = ($urandom_range(0, 99) < 30);
            bus.wr_last = ($urandom_range(0, 99) < 30);
            bus.rd_addr = ($urandom & 32'hFFFF_F000) | 32'(rw << 2) | 32'($urandom_range(0, 3));
            bus.wr_addr = ($urandom & 32'hFFFF_F000) | 32'(ww << 2) | 32'($urandom_range(0, 3));
            bus.wr_data = $urandom;
            bus.wr_strb = 4'($urandom);
            #1;
            checks++;
            if ({bus.rd_gnt, bus.wr_gnt, bus.sram_cs} !== {owner == 1, owner == 2, owner != 0}) begin
                errors++; $display("FAIL rnd_gnt cyc%0d: rd/wr/cs %b required %b", cyc,
                    {bus.rd_gnt, bus.wr_gnt, bus.sram_cs}, {owner == 1, owner == 2, owner != 0});
            end
            checks++;
            if (bus.sram_a !== ADDR_W'(owner == 1 ? rw : owner == 2 ? ww : 0)) begin
                errors++; $display("FAIL rnd_addr cyc%0d: got %h required %h", cyc, bus.sram_a,
                    (owner == 1 ? rw : owner == 2 ? ww : 0));
            end
            checks++;
            if (bus.sram_web !== ((owner == 2 && bus.wr_en) ? ~bus.wr_strb : 4'hF)) begin
                errors++; $display("FAIL rnd_web cyc%0d: got %b", cyc, bus.sram_web);
            end
            checks++;
            if (bus.rd_data_valid !== exp_valid || bus.timeout_err !== exp_to) begin
                errors++; $display("FAIL rnd_flags cyc%0d: valid/err %b%b required %b%b", cyc,
                    bus.rd_data_valid, bus.timeout_err, exp_valid, exp_to);
            end
            if (exp_valid) begin
                checks++;
                if (bus.rd_data !== exp_data) begin
                    errors++; $display("FAIL rnd_data cyc%0d: got %h required %h", cyc, bus.rd_data, exp_data);
                end
            end
            // Burst-level model: who owns the port next, and what memory holds.
            rb = (owner == 1) && bus.rd_en;
            wb = (owner == 2) && bus.wr_en;
            nv = rb;
            nd = ref_mem[rw];
            if (wb) ref_write(ww, bus.wr_data, bus.wr_strb);
            exp_to = 0;
            nxt = owner;
            if (owner == 0) begin
                if (bus.rd_req && bus.wr_req) nxt = prio_wr ? 2 : 1;
                else if (bus.rd_req) nxt = 1;
                else if (bus.wr_req) nxt = 2;
            end else if ((rb && bus.rd_last) || (wb && bus.wr_last)) begin
                nxt = ((owner == 1) ? bus.wr_req : bus.rd_req) ? 3 - owner : 0;
            end else if (rb || wb) begin
                stall = 0;
            end else begin
                stall++;
                if (stall == TIMEOUT) begin
                    nxt = 0;
                    exp_to = 1;
                end
            end
            if (nxt != owner) begin
                stall = 0;
                if (nxt != 0) prio_wr = (nxt == 1);
            end
            owner = nxt;
            exp_valid = nv;
            exp_data = nd;
            step();
        end
        idle_inputs();
        checks++;
        if (reset_wr_cnt !== 0) begin
            errors++; $display("FAIL reset_write: %0d SRAM writes during reset, required 0", reset_wr_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_wr_cnt = 0;
        preload = 1;
        rst_n = 0;
        idle_inputs();
        for (int i = 0; i < MEMW; i++) ref_mem[i] = pat(i);
        test_reset();
        test_read_burst();
        test_write_single();
        test_arbitration();
        test_watchdog();
        test_ungranted();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
